// File: rtl/pcm_stream_out_if.sv
`default_nettype none
// ============================================================================
// Module      : pcm_stream_out_if
// Description : Sample-stream input handshake and framed PCM output bundle
//               for pcm_stream_out.
//               in_valid/in_ready/in_data/in_sop : interleaved sample beats
//               pcm_fs/pcm_data/pcm_mute         : one frame per fs strobe
//               master : sample source / audio formatter side
//               slave  : pcm_stream_out side
// Revision    : 1.0 - initial release
// ============================================================================
interface pcm_stream_out_if #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic [DATA_WIDTH-1:0]          in_data;
  logic                           in_sop;
  logic                           pcm_fs;
  logic [CHANNELS*DATA_WIDTH-1:0] pcm_data;
  logic                           pcm_mute;

  modport master (
    output in_valid, in_data, in_sop,
    input  in_ready, pcm_fs, pcm_data, pcm_mute
  );

  modport slave (
    input  in_valid, in_data, in_sop,
    output in_ready, pcm_fs, pcm_data, pcm_mute
  );
endinterface
`default_nettype wire

// File: rtl/pcm_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : pcm_stream_out
// Description : Assembles interleaved PCM samples into CHANNELS-wide frames,
//               buffers them in a FIFO and emits one frame per fs period
//               (FS_DIVIDER clk cycles). Preloads PRELOAD frames before
//               playback, mutes and counts underruns, honours a soft mute.
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : 1 = run, 0 = flush and idle
//   mute_req       : present zeros (frames are still consumed)
//   clear_status   : clears underrun_count
//   bus (slave)    : sample input handshake and framed PCM output
//   fifo_level     : frames currently buffered
//   underrun_count : saturating underrun event count
// Revision    : 1.0 - initial release
// ============================================================================
module pcm_stream_out #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int FS_DIVIDER = 128,
  parameter int PRELOAD    = 8
) (
  input  wire                          clk,
  input  wire                          reset_n,
  input  wire                          enable,
  input  wire                          mute_req,
  input  wire                          clear_status,
  pcm_stream_out_if.slave              bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  underrun_count
);

  localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w   = c_ptr_w + 1;
  localparam int c_idx_w   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_div_w   = $clog2(FS_DIVIDER);
  localparam int c_frame_w = CHANNELS * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_div_w-1:0]   r_div;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_frame_w-1:0] r_asm;
  logic [c_frame_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;
  logic                 r_in_ready;
  logic                 r_fs;
  logic [c_frame_w-1:0] r_pcm;
  logic                 r_mute;
  logic [15:0]          r_urun;

  logic                 w_accept;
  logic [c_idx_w-1:0]   w_slot;
  logic                 w_last;
  logic                 w_push;
  logic                 w_tick;
  logic                 w_pop;
  logic                 w_underrun;
  logic [c_frame_w-1:0] w_frame;
  logic [c_frame_w-1:0] w_head;
  logic [c_lvl_w-1:0]   w_level_next;

  // in_ready is registered and already reflects "enable && not full", so a
  // beat can only be accepted when there is room for its frame.
  assign w_accept = bus.in_valid && r_in_ready && enable;
  // A start-of-packet beat always lands in channel 0, discarding any partial.
  assign w_slot   = bus.in_sop ? '0 : r_idx;
  assign w_last   = (w_slot == c_idx_w'(CHANNELS - 1));
  assign w_push   = w_accept && w_last;
  assign w_tick   = enable && (r_div == c_div_w'(FS_DIVIDER - 1));

  // Pop/underrun decisions use the level before any push on the same edge.
  assign w_pop      = w_tick && (((r_state == ST_PRIME) && (r_level >= c_lvl_w'(PRELOAD))) ||
                                 ((r_state == ST_PLAY)  && (r_level != '0)));
  assign w_underrun = w_tick && (r_state == ST_PLAY) && (r_level == '0);
  assign w_head     = r_mem[r_rd_ptr];

  always_comb begin
    w_frame = r_asm;
    w_frame[int'(w_slot)*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
  end

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + c_lvl_w'(1);
    end else if (!w_push && w_pop) begin
      w_level_next = r_level - c_lvl_w'(1);
    end
  end

  // Frame storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_frame;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_idx      <= '0;
      r_asm      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_in_ready <= 1'b0;
      r_fs       <= 1'b0;
      r_pcm      <= '0;
      r_mute     <= 1'b1;
      r_urun     <= '0;
    end else begin
      if (!enable) begin
        r_state    <= ST_IDLE;
        r_div      <= '0;
        r_idx      <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_level    <= '0;
        r_in_ready <= 1'b0;
        r_fs       <= 1'b0;
        r_pcm      <= '0;
        r_mute     <= 1'b1;
      end else begin
        r_fs  <= w_tick;
        r_div <= w_tick ? '0 : r_div + c_div_w'(1);

        if (w_accept) begin
          if (w_last) begin
            r_idx <= '0;
          end else begin
            r_idx <= w_slot + c_idx_w'(1);
            r_asm <= w_frame;
          end
        end

        if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        r_level    <= w_level_next;
        r_in_ready <= (w_level_next < c_lvl_w'(FIFO_DEPTH));

        case (r_state)
          ST_IDLE: r_state <= ST_PRIME;
          ST_PRIME, ST_PLAY: begin
            if (w_tick) begin
              if (w_pop) begin
                // A soft mute still consumes the frame to keep the stream timed.
                r_pcm   <= mute_req ? '0 : w_head;
                r_mute  <= mute_req;
                r_state <= ST_PLAY;
              end else begin
                r_pcm  <= '0;
                r_mute <= 1'b1;
                if (r_state == ST_PLAY) r_state <= ST_PRIME;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (clear_status) begin
        r_urun <= w_underrun ? 16'd1 : 16'd0;
      end else if (w_underrun && (r_urun != 16'hFFFF)) begin
        r_urun <= r_urun + 16'd1;
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.pcm_fs     = r_fs;
  assign bus.pcm_data   = r_pcm;
  assign bus.pcm_mute   = r_mute;
  assign fifo_level     = r_level;
  assign underrun_count = r_urun;

endmodule
`default_nettype wire

// File: doc/pcm_stream_out.md
Name: pcm_stream_out

Overview:
- Parametrised successor to the fixed 2-channel, 16-bit PCM output of the playback core.
- Accepts interleaved PCM samples from a streaming source, assembles them into frames of CHANNELS samples, and buffers the frames in a FIFO.
- Emits one frame per fs period, derived from a 128fs (or other FS_DIVIDER) clock.
- Adds preload/restart, underrun detection with mute, a soft mute request and status counters. Sits between the CPU/DMA sample source and the HDMI/I2S audio formatter.

Parameters:
CHANNELS, 2, samples per frame (1..8); channel 0 occupies the pcm_data LSBs.
DATA_WIDTH, 16, bits per sample.
FIFO_DEPTH, 64, frames buffered; must be a power of 2, >= 4.
FS_DIVIDER, 128, clk cycles per fs period (>= CHANNELS+2).
PRELOAD, 8, frames required in the FIFO before playback (re)starts (1..FIFO_DEPTH).

Ports:
clk  in  1  the single clock, 128fs PCM clock.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  1=run; 0=flush and idle.
mute_req  in  1  force muted output; FIFO continues to drain.
clear_status  in  1  one-cycle pulse; clears underrun_count.
in_valid  in  1  sample beat valid.
in_ready  out  1  block can accept a beat.
in_data  in  DATA_WIDTH  sample, two's complement.
in_sop  in  1  beat is channel 0 (frame start).
pcm_fs  out  1  one-cycle frame strobe.
pcm_data  out  CHANNELS*DATA_WIDTH  current frame, held between strobes.
pcm_mute  out  1  1 when the current frame is forced to zero.
fifo_level  out  clog2(FIFO_DEPTH)+1  frames stored.
underrun_count  out  16  saturating underrun event counter.

Behaviour:
- Reset values: in_ready=0, pcm_fs=0, pcm_data=0, pcm_mute=1, fifo_level=0, underrun_count=0, state=IDLE, divider=0, channel index=0.
- All outputs are registered.
- Backpressure: in_ready = enable && (fifo_level < FIFO_DEPTH). A beat is accepted when in_valid && in_ready.
- Channel index: increments per accepted beat and wraps at CHANNELS-1. On the last channel, the assembled frame is written to the FIFO on the same edge.
- Resync: an accepted beat with in_sop=1 while index!=0 discards the partial frame and is stored as channel 0. in_sop=0 at index 0 is accepted normally.
- Simultaneous FIFO push and pop: fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- Divider:
  - Counts 0..FS_DIVIDER-1 while enable=1.
  - pcm_fs=1 for exactly the cycle after the count reaches FS_DIVIDER-1.
  - The first strobe comes FS_DIVIDER cycles after enable rises.
  - pcm_data and pcm_mute update on the same edge that raises pcm_fs, and only then.
- IDLE state:
  - Divider held at 0, FIFO flushed, channel index 0.
  - pcm_data=0, pcm_mute=1, no pcm_fs.
  - enable=1 -> PRIME.
- PRIME state:
  - Strobes still occur; each strobe outputs zero data with pcm_mute=1.
  - At a strobe where fifo_level >= PRELOAD: pop a frame and present it -> PLAY.
- PLAY state, at each strobe:
  - fifo_level > 0: pop and present the frame, pcm_mute=0.
  - fifo_level = 0: present zeros, pcm_mute=1, underrun_count +1 (saturates at 0xFFFF) -> PRIME.
- mute_req=1 at a strobe in PLAY: the frame is still popped, but pcm_data=0 and pcm_mute=1 are presented.
- clear_status: underrun_count=0 next cycle. If an underrun occurs in the same cycle, the count becomes 1.
- enable falling, any state: next cycle go to IDLE, flush the FIFO, reset divider and index, drive pcm_data=0, pcm_mute=1, in_ready=0. underrun_count is retained.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

Test Plan:
Bench parameters: CHANNELS=2, DATA_WIDTH=16, FIFO_DEPTH=8, FS_DIVIDER=8, PRELOAD=4.
1. Reset, then enable=1 with no input -> pcm_fs pulses every 8 cycles (first on cycle 8); pcm_data=0 and pcm_mute=1 at every strobe; underrun_count=0.
2. Push frames (L,R)=(0x0001,0x8001)..(0x0004,0x8004) -> at the strobe after level reaches 4, pcm_data=0x8001_0001 with pcm_mute=0; the next 3 strobes give frames 2..4; the 5th strobe gives zeros, pcm_mute=1, underrun_count=1.
3. Fill 8 frames with no strobe consumption -> in_ready=0 and fifo_level=8; in_valid held high loses no beat; a pop re-raises in_ready the next cycle.
4. Stream 0x0011 (sop=1), then 0x0022 (sop=1), then 0x0033 (sop=0) -> the first beat is discarded; the stored frame is (0x0022,0x0033).
5. mute_req=1 during PLAY with 6 frames queued -> the next strobe gives zeros with pcm_mute=1 and fifo_level drops 6->5; mute_req=0 -> the following strobe presents frame 2.
6. Drop enable mid-play with 5 frames queued -> next cycle fifo_level=0, in_ready=0, pcm_mute=1, no further pcm_fs; underrun_count retained. Pulse clear_status -> underrun_count=0.
